ifetch_unit: RTL and testbench

Instruction fetch front end; the producer side of the decode stage. It holds the PC and issues 32-bit instruction reads on the ibus request/response interface. Returned words are buffered with their PC in a small FIFO and presented to decode through a valid/ready handshake. Redirects from branch, JAL, JALR, MRET and ECALL resolution flush the buffer and discard any stale in-flight response.

---
 rtl/ifetch_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_ifetch_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC register, single-outstanding ibus fetch, instruction FIFO
// Optional: define IFETCH_MISALIGN_EN for misaligned-redirect entries
module ifetch_unit #(
   parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_addr_ok,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
`ifdef IFETCH_MISALIGN_EN
   output logic        inst_misalign,
`endif
   output logic [63:0] inst_pc
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

`ifdef IFETCH_MISALIGN_EN
   localparam logic [63:0] RST_PC = RESET_PC;
`else
   localparam logic [63:0] RST_PC = {RESET_PC[63:2], 2'b00};
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_REQ_DROP,
      S_WAIT_DROP
   } state_t;

   state_t        r_state;
   logic [63:0]   r_pc;
   logic [63:0]   r_req_addr;
   logic          r_ireq_valid;
   logic          r_park;

   logic [31:0]   r_fifo_inst [FIFO_DEPTH];
   logic [63:0]   r_fifo_pc   [FIFO_DEPTH];
`ifdef IFETCH_MISALIGN_EN
   logic          r_fifo_mis  [FIFO_DEPTH];
`endif
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   logic          w_acc;
   logic          w_wait;
   logic          w_done;
   logic          w_drop;
   logic          w_push;
   logic          w_pop;
   logic          w_mis_redir;
   logic [63:0]   w_redir_pc;
   logic [63:0]   w_pc_seq;
   logic [CW-1:0] w_cnt_nx;
   state_t        w_state_nx;
   logic [63:0]   w_pc_nx;
   logic [63:0]   w_req_nx;
   logic          w_park_nx;

`ifdef IFETCH_MISALIGN_EN
   assign w_redir_pc  = redirect_pc;
   assign w_mis_redir = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
   logic w_unused;
   assign w_unused    = ^redirect_pc[1:0];
   assign w_redir_pc  = {redirect_pc[63:2], 2'b00};
   assign w_mis_redir = 1'b0;
`endif

   assign w_acc  = ((r_state == S_REQ) || (r_state == S_REQ_DROP))
                   && iresp_addr_ok;
   assign w_wait = (r_state == S_WAIT) || (r_state == S_WAIT_DROP);
   assign w_done = (w_wait || w_acc) && iresp_data_ok;
   assign w_drop = (r_state == S_REQ_DROP) || (r_state == S_WAIT_DROP);
   assign w_push = w_done && !w_drop && !redirect_valid;
   assign w_pop  = (r_count != '0) && inst_ready && !redirect_valid;
   assign w_pc_seq = r_req_addr + 64'd4;

   // occupancy after this cycle's push/pop (redirect handled separately)
   always_comb begin
      w_cnt_nx = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_cnt_nx = r_count + CW'(1);
         2'b01:   w_cnt_nx = r_count - CW'(1);
         default: w_cnt_nx = r_count;
      endcase
   end

   // next fetch state, PC and request address
   always_comb begin
      w_state_nx = r_state;
      w_pc_nx    = r_pc;
      w_req_nx   = r_req_addr;
      w_park_nx  = r_park;
      if (redirect_valid) begin
         w_pc_nx   = w_redir_pc;
         w_park_nx = w_mis_redir;
         if (w_done || (r_state == S_IDLE)) begin
            w_state_nx = w_mis_redir ? S_IDLE : S_REQ;
            if (!w_mis_redir) begin
               w_req_nx = w_redir_pc;
            end
         end else if (w_acc || w_wait) begin
            w_state_nx = S_WAIT_DROP;
         end else begin
            w_state_nx = S_REQ_DROP;
         end
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (!r_park && (r_count < DEPTH_C)) begin
                  w_state_nx = S_REQ;
                  w_req_nx   = r_pc;
               end
            end
            S_REQ, S_WAIT: begin
               if (w_done) begin
                  w_pc_nx    = w_pc_seq;
                  w_req_nx   = w_pc_seq;
                  w_state_nx = (w_cnt_nx < DEPTH_C) ? S_REQ : S_IDLE;
               end else if (w_acc) begin
                  w_state_nx = S_WAIT;
               end
            end
            S_REQ_DROP, S_WAIT_DROP: begin
               if (w_done) begin
                  if (r_park) begin
                     w_state_nx = S_IDLE;
                  end else begin
                     w_state_nx = S_REQ;
                     w_req_nx   = r_pc;
                  end
               end else if (w_acc) begin
                  w_state_nx = S_WAIT_DROP;
               end
            end
            default: w_state_nx = S_IDLE;
         endcase
      end
   end

   // fetch FSM with registered request outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_pc         <= RST_PC;
         r_req_addr   <= RST_PC;
         r_ireq_valid <= 1'b0;
         r_park       <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_pc         <= w_pc_nx;
         r_req_addr   <= w_req_nx;
         r_park       <= w_park_nx;
         r_ireq_valid <= (w_state_nx == S_REQ)
                         || (w_state_nx == S_REQ_DROP);
      end
   end

   // instruction buffer; redirect flushes and cancels push/pop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_inst[i] <= '0;
            r_fifo_pc[i]   <= '0;
`ifdef IFETCH_MISALIGN_EN
            r_fifo_mis[i]  <= 1'b0;
`endif
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (redirect_valid) begin
         r_rptr <= '0;
         if (w_mis_redir) begin
            r_fifo_inst[0] <= 32'h0000_0013;
            r_fifo_pc[0]   <= redirect_pc;
`ifdef IFETCH_MISALIGN_EN
            r_fifo_mis[0]  <= 1'b1;
`endif
            r_wptr  <= AW'(1);
            r_count <= CW'(1);
         end else begin
            r_wptr  <= '0;
            r_count <= '0;
         end
      end else begin
         if (w_push) begin
            r_fifo_inst[r_wptr] <= iresp_data;
            r_fifo_pc[r_wptr]   <= r_req_addr;
`ifdef IFETCH_MISALIGN_EN
            r_fifo_mis[r_wptr]  <= 1'b0;
`endif
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= w_cnt_nx;
      end
   end

   assign ireq_valid = r_ireq_valid;
   assign ireq_addr  = r_req_addr;
   assign inst_valid = (r_count != '0);
   assign inst       = r_fifo_inst[r_rptr];
   assign inst_pc    = r_fifo_pc[r_rptr];
`ifdef IFETCH_MISALIGN_EN
   assign inst_misalign = r_fifo_mis[r_rptr];
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed bench for ifetch_unit
// Memory model answers with data = addr[31:0] ^ 32'h13
module tb_ifetch_unit;

   logic        clk;
   logic        reset;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_addr_ok;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;
`ifdef IFETCH_MISALIGN_EN
   logic        inst_misalign;
`endif

   ifetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .ireq_valid    (ireq_valid),
      .ireq_addr     (ireq_addr),
      .iresp_addr_ok (iresp_addr_ok),
      .iresp_data_ok (iresp_data_ok),
      .iresp_data    (iresp_data),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst          (inst),
`ifdef IFETCH_MISALIGN_EN
      .inst_misalign (inst_misalign),
`endif
      .inst_pc       (inst_pc)
   );

   int n_chk  = 0;
   int n_fail = 0;

   int m_dly  = 1;
   int m_hold = 0;
   logic        p_pend = 1'b0;
   int          p_cnt  = 0;
   logic [63:0] p_addr = '0;

   logic [63:0] q_req [$];
   logic [63:0] qp_pc [$];
   logic [31:0] qp_in [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fdat(input logic [63:0] a);
      return a[31:0] ^ 32'h0000_0013;
   endfunction

   function automatic logic [63:0] qreq(input int i);
      return (q_req.size() > i) ? q_req[i] : '1;
   endfunction

   function automatic logic [63:0] qpc(input int i);
      return (qp_pc.size() > i) ? qp_pc[i] : '1;
   endfunction

   function automatic logic [31:0] qin(input int i);
      return (qp_in.size() > i) ? qp_in[i] : '1;
   endfunction

   // memory responder and decode-side pop monitor
   always @(negedge clk) begin
      iresp_addr_ok = 1'b0;
      iresp_data_ok = 1'b0;
      if (p_pend) begin
         if (p_cnt <= 1) begin
            iresp_data_ok = 1'b1;
            iresp_data    = fdat(p_addr);
            p_pend        = 1'b0;
         end else begin
            p_cnt--;
         end
      end else if (ireq_valid) begin
         if (m_hold > 0) begin
            m_hold--;
         end else begin
            iresp_addr_ok = 1'b1;
            q_req.push_back(ireq_addr);
            if (m_dly == 0) begin
               iresp_data_ok = 1'b1;
               iresp_data    = fdat(ireq_addr);
            end else begin
               p_pend = 1'b1;
               p_cnt  = m_dly;
               p_addr = ireq_addr;
            end
         end
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
         qp_pc.push_back(inst_pc);
         qp_in.push_back(inst);
      end
   end

   // invariant: never push into a full buffer
   always @(negedge clk) begin
      if (reset && dut.w_push && (dut.r_count == 2)) begin
         chk("push_full", 64'd1, 64'd0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic redir(input logic [63:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
   endtask

   task automatic wait_iv(input string tag);
      int k;
      k = 0;
      while (!inst_valid && k < 30) begin
         cyc(1);
         k++;
      end
      chk(tag, {63'd0, inst_valid}, 64'd1);
   endtask

   task automatic wait_rq(input string tag);
      int k;
      k = 0;
      while (!ireq_valid && k < 30) begin
         cyc(1);
         k++;
      end
      chk(tag, {63'd0, ireq_valid}, 64'd1);
   endtask

   initial begin
      logic seen;
      reset          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      iresp_addr_ok  = 1'b0;
      iresp_data_ok  = 1'b0;
      iresp_data     = '0;
      inst_ready     = 1'b0;

      cyc(3);
      chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
      chk("rst_ireq_addr", ireq_addr, 64'h8000_0000);
      chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
      chk("rst_inst", {32'd0, inst}, 64'd0);
      chk("rst_inst_pc", inst_pc, 64'd0);
`ifdef IFETCH_MISALIGN_EN
      chk("rst_misalign", {63'd0, inst_misalign}, 64'd0);
`endif
      reset = 1'b1;

      // fetch with data one cycle after addr_ok, decode stalled
      cyc(1);
      chk("t1_req0_v", {63'd0, ireq_valid}, 64'd1);
      chk("t1_req0_a", ireq_addr, 64'h8000_0000);
      cyc(1);
      chk("t1_wait_v", {63'd0, ireq_valid}, 64'd0);
      chk("t1_wait_iv", {63'd0, inst_valid}, 64'd0);
      cyc(1);
      chk("t1_iv", {63'd0, inst_valid}, 64'd1);
      chk("t1_ipc", inst_pc, 64'h8000_0000);
      chk("t1_inst", {32'd0, inst}, {32'd0, fdat(64'h8000_0000)});
      chk("t1_req1_a", ireq_addr, 64'h8000_0004);
      chk("t1_req1_v", {63'd0, ireq_valid}, 64'd1);
      cyc(2);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         seen = seen | ireq_valid;
         cyc(1);
      end
      chk("t1_no_req_full", {63'd0, seen}, 64'd0);
      chk("t1_nreq", 64'(q_req.size()), 64'd2);
      chk("t1_head_pc", inst_pc, 64'h8000_0000);

      // same-cycle addr_ok/data_ok, decode always ready
      m_dly = 0;
      q_req.delete();
      qp_pc.delete();
      qp_in.delete();
      inst_ready = 1'b1;
      cyc(12);
      inst_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_pc%0d", i), qpc(i),
             64'h8000_0000 + 64'(4 * i));
         chk($sformatf("t2_in%0d", i), {32'd0, qin(i)},
             {32'd0, fdat(64'h8000_0000 + 64'(4 * i))});
      end
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t2_req%0d", i), qreq(i),
             64'h8000_0008 + 64'(4 * i));
      end
      cyc(8);

      // redirect while a response is outstanding
      m_dly = 3;
      q_req.delete();
      redir(64'h8000_0200);
      chk("t3_flush_iv", {63'd0, inst_valid}, 64'd0);
      chk("t3_req_a", ireq_addr, 64'h8000_0200);
      cyc(1);
      chk("t3_in_wait", {63'd0, ireq_valid}, 64'd0);
      redir(64'h8000_0100);
      wait_rq("t3_wait_req");
      chk("t3_tgt_a", ireq_addr, 64'h8000_0100);
      wait_iv("t3_wait_iv");
      chk("t3_ipc", inst_pc, 64'h8000_0100);
      chk("t3_inst", {32'd0, inst}, {32'd0, fdat(64'h8000_0100)});
      chk("t3_req1", qreq(1), 64'h8000_0100);

      // redirect while the request is held unaccepted
      m_dly = 1;
      cyc(20);
      q_req.delete();
      m_hold = 3;
      redir(64'h8000_0300);
      chk("t4_flush_iv", {63'd0, inst_valid}, 64'd0);
      chk("t4_req_a0", ireq_addr, 64'h8000_0300);
      redir(64'h8000_0400);
      chk("t4_hold_v1", {63'd0, ireq_valid}, 64'd1);
      chk("t4_hold_a1", ireq_addr, 64'h8000_0300);
      cyc(1);
      chk("t4_hold_a2", ireq_addr, 64'h8000_0300);
      cyc(1);
      chk("t4_hold_v3", {63'd0, ireq_valid}, 64'd1);
      chk("t4_hold_a3", ireq_addr, 64'h8000_0300);
      cyc(1);
      chk("t4_acc_v", {63'd0, ireq_valid}, 64'd0);
      cyc(1);
      chk("t4_tgt_v", {63'd0, ireq_valid}, 64'd1);
      chk("t4_tgt_a", ireq_addr, 64'h8000_0400);
      wait_iv("t4_wait_iv");
      chk("t4_ipc", inst_pc, 64'h8000_0400);
      chk("t4_inst", {32'd0, inst}, {32'd0, fdat(64'h8000_0400)});
      chk("t4_req1", qreq(1), 64'h8000_0400);

      // full buffer, pop and redirect in the same cycle
      cyc(12);
      chk("t5_full_iv", {63'd0, inst_valid}, 64'd1);
      chk("t5_full_rv", {63'd0, ireq_valid}, 64'd0);
      inst_ready = 1'b1;
      redir(64'h8000_0500);
      inst_ready = 1'b0;
      chk("t5_flush_iv", {63'd0, inst_valid}, 64'd0);
      chk("t5_req_a", ireq_addr, 64'h8000_0500);
      wait_iv("t5_wait_iv");
      chk("t5_ipc", inst_pc, 64'h8000_0500);

      // redirect to a pc with nonzero low bits
      cyc(12);
      redir(64'h8000_0602);
`ifdef IFETCH_MISALIGN_EN
      chk("t6_rv", {63'd0, ireq_valid}, 64'd0);
      chk("t6_iv", {63'd0, inst_valid}, 64'd1);
      chk("t6_mis", {63'd0, inst_misalign}, 64'd1);
      chk("t6_ipc", inst_pc, 64'h8000_0602);
      chk("t6_inst", {32'd0, inst}, 64'h13);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seen = seen | ireq_valid;
         cyc(1);
      end
      chk("t6_parked", {63'd0, seen}, 64'd0);
      redir(64'h8000_0700);
      chk("t6_rec_a", ireq_addr, 64'h8000_0700);
      wait_iv("t6_wait_iv");
      chk("t6_rec_mis", {63'd0, inst_misalign}, 64'd0);
      chk("t6_rec_ipc", inst_pc, 64'h8000_0700);
`else
      chk("t6_rv", {63'd0, ireq_valid}, 64'd1);
      chk("t6_align_a", ireq_addr, 64'h8000_0600);
      wait_iv("t6_wait_iv");
      chk("t6_ipc", inst_pc, 64'h8000_0600);
`endif

      // PC wraps modulo 2^64
      cyc(12);
      m_dly = 0;
      q_req.delete();
      qp_pc.delete();
      qp_in.delete();
      inst_ready = 1'b1;
      redir(64'hFFFF_FFFF_FFFF_FFFC);
      cyc(8);
      inst_ready = 1'b0;
      chk("t7_req0", qreq(0), 64'hFFFF_FFFF_FFFF_FFFC);
      chk("t7_req1", qreq(1), 64'h0);
      chk("t7_pc0", qpc(0), 64'hFFFF_FFFF_FFFF_FFFC);
      chk("t7_pc1", qpc(1), 64'h0);
      chk("t7_in1", {32'd0, qin(1)}, 64'h13);
      cyc(4);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
